pool_cfg_apb_master: RTL and testbench

APB initiator that runs one complete pooling job on a `pool_top` instance through its APB register file. It accepts a job command (`flen`, `in_channel`), programs the configuration registers, asserts start and polls done. It then reads the cycle counter, clears start and returns the count. It sits between the test/control logic and the `PADDR`/`PSEL`/`PENABLE`/`PWRITE`/`PWDATA`/`PRDATA`/`PREADY`/`PSLVERR` port group of the pool block.

---
 rtl/pool_apb_pkg.sv | 71 +++++++
 rtl/pool_cfg_apb_master_apb_xfer.sv | 75 +++++++
 rtl/pool_cfg_apb_master.sv | 162 ++++++++++++++++
 tb/tb_pool_cfg_apb_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_apb_pkg.sv
// Shared constants and types for the pool configuration APB initiator.
package pool_apb_pkg;

    localparam logic [31:0] OFF_CTRL        = 32'h00;
    localparam logic [31:0] OFF_STATUS      = 32'h04;
    localparam logic [31:0] OFF_CLK_COUNTER = 32'h08;
    localparam logic [31:0] OFF_FLEN        = 32'h0C;
    localparam logic [31:0] OFF_IN_CHANNEL  = 32'h10;

    localparam int FLEN_W  = 6;
    localparam int IN_CH_W = 9;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_SLVERR  = 2'd1,
        ERR_TIMEOUT = 2'd2
    } res_err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_GAP,
        S_RESULT
    } state_e;

    typedef enum logic [2:0] {
        STEP_FLEN,
        STEP_IN_CH,
        STEP_START,
        STEP_POLL,
        STEP_COUNT,
        STEP_STOP
    } step_e;

    function automatic logic [31:0] step_offset(input step_e s);
        case (s)
            STEP_FLEN:  return OFF_FLEN;
            STEP_IN_CH: return OFF_IN_CHANNEL;
            STEP_POLL:  return OFF_STATUS;
            STEP_COUNT: return OFF_CLK_COUNTER;
            default:    return OFF_CTRL;
        endcase
    endfunction

    function automatic logic step_is_write(input step_e s);
        return (s != STEP_POLL) && (s != STEP_COUNT);
    endfunction

    function automatic logic [31:0] step_wdata(input step_e s,
                                               input logic [FLEN_W-1:0] flen,
                                               input logic [IN_CH_W-1:0] in_ch);
        case (s)
            STEP_FLEN:  return {26'b0, flen};
            STEP_IN_CH: return {23'b0, in_ch};
            STEP_START: return 32'd1;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic step_e step_next(input step_e s);
        case (s)
            STEP_FLEN:  return STEP_IN_CH;
            STEP_IN_CH: return STEP_START;
            STEP_START: return STEP_POLL;
            STEP_POLL:  return STEP_COUNT;
            default:    return STEP_STOP;
        endcase
    endfunction

endpackage

// File: rtl/pool_cfg_apb_master_apb_xfer.sv
// Single-transfer APB engine: registered SETUP/ACCESS phases, done pulse on the completing ACCESS cycle.
module apb_xfer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        slverr,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;

    assign done   = psel_q & penable_q & pready;
    assign rdata  = prdata;
    assign slverr = done & pslverr;

    // A start on the completing cycle chains straight into the next SETUP.
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (start) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = addr;
            pwrite_d  = write;
            pwdata_d  = wdata;
        end else if (psel_q && !penable_q) begin
            penable_d = 1'b1;
        end else if (done) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;

endmodule

// File: rtl/pool_cfg_apb_master.sv
// Runs one pooling job over APB: program FLEN/IN_CHANNEL, start, poll done, read counter, stop.
//   state    | meaning
//   S_IDLE   | waiting for a command
//   S_SETUP  | APB setup phase of the current step
//   S_ACCESS | APB access phase, waiting for PREADY
//   S_GAP    | idle spacing between STATUS polls
//   S_RESULT | result presented until res_ready
module pool_cfg_apb_master
    import pool_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_GAP  = 4,
    parameter logic [31:0] POLL_MAX  = 32'd1_000_000
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_flen,
    input  logic [8:0]  cmd_in_channel,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_cycles,
    output logic [1:0]  res_err,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [31:0] GAP_LOAD = 32'(POLL_GAP);

    state_e               state_q, state_d;
    step_e                step_q, step_d;
    logic [FLEN_W-1:0]    flen_q, flen_d;
    logic [IN_CH_W-1:0]   in_ch_q, in_ch_d;
    logic [31:0]          poll_cnt_q, poll_cnt_d, poll_inc;
    logic [31:0]          gap_cnt_q, gap_cnt_d;
    logic [31:0]          res_cycles_q, res_cycles_d;
    res_err_e             res_err_q, res_err_d;

    logic        xfer_start, xfer_done, xfer_slverr;
    logic [31:0] xfer_rdata;

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        flen_d       = flen_q;
        in_ch_d      = in_ch_q;
        poll_cnt_d   = poll_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        res_cycles_d = res_cycles_q;
        res_err_d    = res_err_q;
        xfer_start   = 1'b0;
        poll_inc     = (poll_cnt_q == 32'hFFFF_FFFF) ? poll_cnt_q : poll_cnt_q + 32'd1;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    flen_d       = cmd_flen;
                    in_ch_d      = cmd_in_channel;
                    step_d       = STEP_FLEN;
                    poll_cnt_d   = '0;
                    res_cycles_d = '0;
                    res_err_d    = ERR_OK;
                    xfer_start   = 1'b1;
                    state_d      = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (xfer_done) begin
                    if (xfer_slverr) begin
                        res_err_d    = ERR_SLVERR;
                        res_cycles_d = '0;
                        state_d      = S_RESULT;
                    end else if (step_q == STEP_POLL && !xfer_rdata[0]) begin
                        poll_cnt_d = poll_inc;
                        if (poll_inc >= POLL_MAX) begin
                            res_err_d = ERR_TIMEOUT;
                            state_d   = S_RESULT;
                        end else if (POLL_GAP == 0) begin
                            xfer_start = 1'b1;
                            state_d    = S_SETUP;
                        end else begin
                            gap_cnt_d = GAP_LOAD;
                            state_d   = S_GAP;
                        end
                    end else if (step_q == STEP_STOP) begin
                        state_d = S_RESULT;
                    end else begin
                        if (step_q == STEP_COUNT) res_cycles_d = xfer_rdata;
                        step_d     = step_next(step_q);
                        xfer_start = 1'b1;
                        state_d    = S_SETUP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= 32'd1) begin
                    xfer_start = 1'b1;
                    state_d    = S_SETUP;
                end else begin
                    gap_cnt_d = gap_cnt_q - 32'd1;
                end
            end
            S_RESULT: if (res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q      <= S_IDLE;
            step_q       <= STEP_FLEN;
            flen_q       <= '0;
            in_ch_q      <= '0;
            poll_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            res_cycles_q <= '0;
            res_err_q    <= ERR_OK;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            flen_q       <= flen_d;
            in_ch_q      <= in_ch_d;
            poll_cnt_q   <= poll_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            res_cycles_q <= res_cycles_d;
            res_err_q    <= res_err_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign res_valid  = (state_q == S_RESULT);
    assign res_cycles = res_cycles_q;
    assign res_err    = res_err_q;

    apb_xfer u_xfer (
        .clk     (CLK),
        .resetn  (RESETN),
        .start   (xfer_start),
        .addr    (BASE_ADDR + step_offset(step_d)),
        .write   (step_is_write(step_d)),
        .wdata   (step_wdata(step_d, flen_d, in_ch_d)),
        .done    (xfer_done),
        .rdata   (xfer_rdata),
        .slverr  (xfer_slverr),
        .paddr   (PADDR),
        .psel    (PSEL),
        .penable (PENABLE),
        .pwrite  (PWRITE),
        .pwdata  (PWDATA),
        .prdata  (PRDATA),
        .pready  (PREADY),
        .pslverr (PSLVERR)
    );

endmodule

// File: tb/tb_pool_cfg_apb_master.sv
// Bench for pool_cfg_apb_master: APB slave model with wait states and error injection, job-level reference model.
module tb_pool_cfg_apb_master;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          GAP  = 4;
    localparam int          PMAX = 3;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        cmd_valid, cmd_ready, res_valid, res_ready;
    logic [5:0]  cmd_flen;
    logic [8:0]  cmd_in_channel;
    logic [31:0] res_cycles;
    logic [1:0]  res_err;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    always #5 CLK = ~CLK;

    pool_cfg_apb_master #(
        .BASE_ADDR (BASE),
        .POLL_GAP  (GAP),
        .POLL_MAX  (32'd3)
    ) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_flen       (cmd_flen),
        .cmd_in_channel (cmd_in_channel),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_cycles     (res_cycles),
        .res_err        (res_err),
        .PADDR          (PADDR),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PWDATA         (PWDATA),
        .PRDATA         (PRDATA),
        .PREADY         (PREADY),
        .PSLVERR        (PSLVERR)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- APB slave model ----------------
    typedef struct {bit wr; logic [31:0] addr; logic [31:0] data; int acc;} xfer_t;
    typedef struct {bit wr; logic [31:0] off; logic [31:0] data;} exp_t;
    xfer_t log_q[$];
    exp_t  exp_q[$];

    int          sl_ws, sl_k, sl_err_off, sl_polls, ws_cnt, stab_err;
    logic [31:0] sl_cnt, su_addr, su_wdata, off, rd, junk;
    logic        su_write;

    always @(negedge CLK) begin
        if (PSEL && !PENABLE) begin
            su_addr  = PADDR;
            su_wdata = PWDATA;
            su_write = PWRITE;
            ws_cnt   = 0;
        end
        if (PENABLE && !PSEL) stab_err++;
        if (PSEL && (res_valid || cmd_ready)) stab_err++;
        if (PSEL && PENABLE) begin
            if (PADDR !== su_addr || PWDATA !== su_wdata || PWRITE !== su_write) stab_err++;
            if (ws_cnt < sl_ws) begin
                ws_cnt++;
                PREADY  = 1'b0;
                PSLVERR = 1'b1;
                PRDATA  = $urandom;
            end else begin
                off     = PADDR - BASE;
                PREADY  = 1'b1;
                PSLVERR = (sl_err_off >= 0) && (off == 32'(sl_err_off));
                junk    = $urandom;
                rd      = 32'd0;
                if (!PWRITE && off == 32'h04) rd = {junk[31:1], (sl_k != 0 && sl_polls + 1 >= sl_k)};
                if (!PWRITE && off == 32'h08) rd = sl_cnt;
                PRDATA = rd;
                if (!PSLVERR) begin
                    if (PWRITE && off == 32'h00 && PWDATA[0]) sl_polls = 0;
                    if (!PWRITE && off == 32'h04) sl_polls++;
                end
                log_q.push_back('{PWRITE, PADDR, PWRITE ? PWDATA : rd, ws_cnt + 1});
            end
        end else begin
            PREADY  = 1'($urandom_range(0, 1));
            PSLVERR = 1'b1;
            PRDATA  = $urandom;
        end
    end

    // ---------------- reference model: expected APB trace of one job ----------------
    function automatic void push_exp(input bit wr, input logic [31:0] o, input logic [31:0] d);
        exp_t e;
        e.wr = wr; e.off = o; e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic model(input int flen, input int inch, input int k, input int err_off,
                         input logic [31:0] cnt, input int ws,
                         output int e_err, output logic [31:0] e_cyc, output int e_lat);
        bit done = 0;
        int nreads = 0;
        exp_q.delete();
        push_exp(1, 32'h0C, 32'(flen));
        push_exp(1, 32'h10, 32'(inch));
        push_exp(1, 32'h00, 32'd1);
        for (int p = 1; p <= PMAX; p++) begin
            push_exp(0, 32'h04, 32'd0);
            if (k != 0 && p >= k) begin done = 1; break; end
        end
        if (done) begin
            push_exp(0, 32'h08, cnt);
            push_exp(1, 32'h00, 32'd0);
        end
        e_err = done ? 0 : 2;
        e_cyc = done ? cnt : 32'd0;
        if (err_off >= 0) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].off == 32'(err_off)) begin
                    while (exp_q.size() > i + 1) void'(exp_q.pop_back());
                    e_err = 1;
                    e_cyc = 32'd0;
                    break;
                end
            end
        end
        foreach (exp_q[i]) if (exp_q[i].off == 32'h04) nreads++;
        e_lat = 1 + exp_q.size() * (2 + ws) + ((nreads > 0) ? nreads - 1 : 0) * GAP;
    endtask

    // ---------------- one job, end to end ----------------
    task automatic run_job(input string nm, input int flen, input int inch, input int k,
                           input int err_off, input int ws, input logic [31:0] cnt, input int hold,
                           input bit use_tbl, input int t_err, input logic [31:0] t_cyc);
        int m_err, m_lat, lat, hold_bad, n;
        logic [31:0] m_cyc, e_cyc;
        int e_err;
        sl_ws = ws; sl_k = k; sl_err_off = err_off; sl_cnt = cnt;
        stab_err = 0;
        log_q.delete();
        model(flen, inch, k, err_off, cnt, ws, m_err, m_cyc, m_lat);
        e_err = use_tbl ? t_err : m_err;
        e_cyc = use_tbl ? t_cyc : m_cyc;

        @(negedge CLK);
        chk({nm, " cmd_ready idle"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_flen = 6'(flen); cmd_in_channel = 9'(inch);
        @(negedge CLK);
        cmd_valid = 1'b0; cmd_flen = 6'($urandom); cmd_in_channel = 9'($urandom);
        lat = 1;
        while (res_valid !== 1'b1 && lat < 5000) begin
            lat++;
            @(negedge CLK);
        end
        if (lat >= 5000) begin
            errors++; checks++;
            $display("FAIL %s res_valid timeout: got none after %0d cycles, expected %0d", nm, lat, m_lat);
        end
        chk({nm, " latency"}, 64'(lat), 64'(m_lat));
        chk({nm, " res_err"}, 64'(res_err), 64'(e_err));
        chk({nm, " res_cycles"}, 64'(res_cycles), 64'(e_cyc));

        hold_bad = 0;
        if (hold > 0) cmd_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            if (res_valid !== 1'b1 || res_cycles !== e_cyc || res_err !== 2'(e_err) || cmd_ready !== 1'b0 || PSEL !== 1'b0)
                hold_bad++;
        end
        if (hold > 0) chk({nm, " result held"}, 64'(hold_bad), 64'd0);
        res_ready = 1'b1;
        @(negedge CLK);
        res_ready = 1'b0;
        chk({nm, " release res_valid/cmd_ready"}, {62'd0, res_valid, cmd_ready}, 64'd1);
        cmd_valid = 1'b0;

        chk({nm, " trace length"}, 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (log_q[i].wr != exp_q[i].wr || log_q[i].addr !== BASE + exp_q[i].off ||
                (exp_q[i].wr && log_q[i].data !== exp_q[i].data) || log_q[i].acc != ws + 1) begin
                errors++;
                $display("FAIL %s trace[%0d]: got wr=%0d addr=%0h data=%0h acc=%0d, expected wr=%0d addr=%0h data=%0h acc=%0d",
                         nm, i, log_q[i].wr, log_q[i].addr, log_q[i].data, log_q[i].acc,
                         exp_q[i].wr, BASE + exp_q[i].off, exp_q[i].data, ws + 1);
            end
        end
        chk({nm, " apb stability"}, 64'(stab_err), 64'd0);
    endtask

    typedef struct {
        int flen; int inch; int k; int err_off; int ws;
        logic [31:0] cnt; int hold; int e_err; logic [31:0] e_cyc;
    } vec_t;
    vec_t tbl[9];
    int   offs[5] = '{0, 4, 8, 12, 16};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int hit, r;
        tbl[0] = '{6, 3, 1, -1, 0, 32'h0000_1234, 0, 0, 32'h0000_1234};
        tbl[1] = '{6, 3, 2, -1, 2, 32'h0000_1234, 0, 0, 32'h0000_1234};
        tbl[2] = '{6, 3, 1, 16, 0, 32'd55, 0, 1, 32'd0};
        tbl[3] = '{9, 100, 0, -1, 0, 32'd77, 10, 2, 32'd0};
        tbl[4] = '{63, 511, 3, -1, 1, 32'hFFFF_FFFF, 2, 0, 32'hFFFF_FFFF};
        tbl[5] = '{1, 1, 2, 4, 0, 32'd5, 0, 1, 32'd0};
        tbl[6] = '{0, 0, 1, 8, 3, 32'd9, 1, 1, 32'd0};
        tbl[7] = '{33, 256, 4, -1, 0, 32'h0000_ABCD, 0, 2, 32'd0};
        tbl[8] = '{5, 7, 1, 0, 0, 32'd3, 0, 1, 32'd0};

        RESETN = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_flen = '0; cmd_in_channel = '0;
        sl_ws = 0; sl_k = 0; sl_err_off = -1; sl_cnt = '0; sl_polls = 0; stab_err = 0;
        repeat (3) @(negedge CLK);
        chk("reset cmd_ready/res_valid", {62'd0, cmd_ready, res_valid}, 64'd2);
        chk("reset psel/penable/pwrite", {61'd0, PSEL, PENABLE, PWRITE}, 64'd0);
        chk("reset paddr/pwdata", {PADDR, PWDATA}, 64'd0);
        chk("reset res_cycles/res_err", {30'd0, res_err, res_cycles}, 64'd0);
        RESETN = 1'b1;

        for (int i = 0; i < 9; i++)
            run_job($sformatf("vec%0d", i), tbl[i].flen, tbl[i].inch, tbl[i].k, tbl[i].err_off,
                    tbl[i].ws, tbl[i].cnt, tbl[i].hold, 1'b1, tbl[i].e_err, tbl[i].e_cyc);

        // Reset during the ACCESS of the CTRL=1 write, then a clean job.
        sl_ws = 3; sl_k = 1; sl_err_off = -1;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_flen = 6'd6; cmd_in_channel = 9'd3;
        @(negedge CLK);
        cmd_valid = 1'b0;
        hit = 0;
        for (int i = 0; i < 100 && hit == 0; i++) begin
            if (PSEL && PENABLE && PWRITE && PADDR == BASE && PWDATA == 32'd1) hit = 1;
            else @(negedge CLK);
        end
        chk("midreset reached ctrl access", 64'(hit), 64'd1);
        RESETN = 1'b0;
        @(negedge CLK);
        RESETN = 1'b1;
        chk("midreset psel/penable", {62'd0, PSEL, PENABLE}, 64'd0);
        chk("midreset cmd_ready/res_valid", {62'd0, cmd_ready, res_valid}, 64'd2);
        sl_polls = 0;
        run_job("post_reset", 6, 3, 1, -1, 0, 32'h0000_0042, 0, 1'b1, 0, 32'h0000_0042);

        for (int j = 0; j < 20; j++) begin
            r = $urandom_range(0, 10);
            run_job($sformatf("rnd%0d", j), $urandom_range(0, 63), $urandom_range(0, 511),
                    $urandom_range(0, 4), (r < 6) ? -1 : offs[r-6], $urandom_range(0, 3),
                    $urandom, $urandom_range(0, 3), 1'b0, 0, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
